conv_out_collector: RTL and testbench
=====================================

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 2: convolution kernel edge; must match the upstream PE.
REQ-002 SHALL have parameter FM_SIZE, default 4: input feature-map edge; must match the upstream PE.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: signed width of the requantized output word.
REQ-004 SHALL derive localparam OUT_DIM = FM_SIZE-KERNEL_SIZE+1 and localparam N = OUT_DIM*OUT_DIM (frame length, buffer depth).
REQ-005 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_P, input, 48: signed PE result.
REQ-008 SHALL have port i_en, input, 1: i_P valid; connects to the PE o_en.
REQ-009 SHALL have port i_shift, input, 6: right-shift amount; sampled together with i_P.
REQ-010 SHALL have port i_relu, input, 1: ReLU enable; sampled together with i_P.
REQ-011 SHALL have port o_data, output, OUT_WIDTH: signed output word.
REQ-012 SHALL have port o_valid, output, 1: o_data valid.
REQ-013 SHALL have port i_ready, input, 1: downstream accepts o_data.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse when a frame is fully drained.
REQ-015 SHALL have port o_overflow, output, 1: sticky flag; at least one sample saturated.
REQ-016 SHALL have port o_drop, output, 1: sticky flag; at least one sample arrived while in DRAIN.

Function
REQ-017 SHALL requantize each accepted sample in a one-cycle registered stage:
- arithmetic right shift of i_P by i_shift (floor toward -inf);
- if i_relu=1, negative results become 0;
- saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-018 SHALL set o_overflow whenever REQ-017 saturation changes the value; it stays 1 until i_rst.
REQ-019 SHALL implement FSM states COLLECT, FLUSH and DRAIN; reset state is COLLECT.
REQ-020 In COLLECT, each cycle with i_en=1 SHALL accept one sample; write addresses run 0..N-1 in arrival (raster) order.
REQ-021 When sample N-1 is accepted at cycle T, the FSM SHALL enter FLUSH at T+1 and DRAIN at T+2; the stage-register write completes in FLUSH.
REQ-022 In FLUSH and DRAIN, i_en=1 SHALL be ignored (nothing written, counters unchanged) and SHALL set o_drop, which stays 1 until i_rst.
REQ-023 In DRAIN, o_valid SHALL first assert at T+3 with buffer entry 0 on o_data (registered read).
REQ-024 Read handshake: a word transfers on any cycle with o_valid=1 and i_ready=1.
REQ-025 With i_ready held at 1, the next entry SHALL appear in the following cycle, with no bubbles.
REQ-026 While o_valid=1 and i_ready=0, o_data and o_valid SHALL hold stable.
REQ-027 On the transfer of entry N-1:
- o_valid SHALL deassert the next cycle;
- o_done SHALL pulse high for exactly that next cycle;
- the FSM SHALL return to COLLECT in that same cycle, with write and read pointers at 0.
REQ-028 In the o_done cycle, an i_en=1 sample SHALL be accepted as entry 0 of the next frame.
REQ-029 o_valid SHALL be 0 in COLLECT and FLUSH.
REQ-030 Buffer storage SHALL be N x OUT_WIDTH bits, inferable as distributed or block RAM; buffer contents are not reset.

Reset
REQ-031 i_rst=1 SHALL, at the next edge, force:
- FSM to COLLECT, pointers to 0, stage register invalid;
- o_valid=0, o_done=0, o_overflow=0, o_drop=0, o_data=0.
REQ-032 Reset mid-frame (any state) SHALL discard the partial frame; the first i_en sample after reset is entry 0.

Verification (KERNEL_SIZE=2, FM_SIZE=4, OUT_WIDTH=16, so N=9)
REQ-033 Reset: assert i_rst 2 cycles with i_en=1 -> all outputs 0; no sample counted.
REQ-034 Nominal frame: i_P=1..9 on 9 consecutive cycles (last at T), i_shift=0, i_relu=0, i_ready=1 ->
- o_data=1..9 on cycles T+3..T+11;
- o_done=1 only at T+12;
- flags remain 0.
REQ-035 Saturation/ReLU, each in its own frame slot:
- i_P=100000 -> 32767, o_overflow=1;
- i_P=-100000 -> -32768;
- i_P=-5 with i_relu=1 -> 0.
REQ-036 Shift: i_shift=4 -> i_P=-17 gives -2; i_P=35 gives 2; i_P=-16 gives -1.
REQ-037 Backpressure: i_ready toggling 1,0,0,1,... during DRAIN -> each entry delivered exactly once, in order, and held stable while stalled.
REQ-038 Drop and mid-reset:
- i_en=1 with i_P=77 during DRAIN -> o_drop=1 and the output sequence is unchanged;
- i_rst mid-DRAIN -> o_valid=0 next cycle, and a subsequent 9-sample frame drains correctly.

Source files
------------

// File: rtl/conv_out_collector.sv
// Collects one frame of PE results, requantizes each sample to OUT_WIDTH bits and
// buffers it, then drains the frame in raster order over a valid/ready handshake.
module conv_out_collector #(
   parameter int KERNEL_SIZE = 2,
   parameter int FM_SIZE     = 4,
   parameter int OUT_WIDTH   = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic signed [47:0]          i_P,
   input  logic                        i_en,
   input  logic [5:0]                  i_shift,
   input  logic                        i_relu,
   output logic signed [OUT_WIDTH-1:0] o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_done,
   output logic                        o_overflow,
   output logic                        o_drop
);

   localparam int OUT_DIM = FM_SIZE - KERNEL_SIZE + 1;
   localparam int N       = OUT_DIM * OUT_DIM;
   localparam int AW      = (N > 1) ? $clog2(N) : 1;
   localparam int RW      = $clog2(N + 1);

   localparam logic signed [47:0] MAX_V = (48'sd1 <<< (OUT_WIDTH - 1)) - 48'sd1;
   localparam logic signed [47:0] MIN_V = -(48'sd1 <<< (OUT_WIDTH - 1));

   typedef enum logic [1:0] {COLLECT, FLUSH, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [RW-1:0]          rd_ptr_q, rd_ptr_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   drop_q, drop_d;
   logic                   ovf_q;
   logic                   stage_vld_q;
   logic [AW-1:0]          stage_addr_q;
   logic signed [OUT_WIDTH-1:0] stage_data_q;
   logic signed [OUT_WIDTH-1:0] rd_data_q;
   logic signed [OUT_WIDTH-1:0] mem [N];

   logic                   accept, fetch, last_xfer;
   logic signed [47:0]     shifted, rectified;
   logic signed [OUT_WIDTH-1:0] sat_val;
   logic                   sat_hit;

   // Arithmetic shift floors toward -inf; ReLU precedes saturation.
   always_comb begin
      shifted   = i_P >>> i_shift;
      rectified = (i_relu && shifted[47]) ? '0 : shifted;
      sat_hit   = 1'b1;
      if (rectified > MAX_V) begin
         sat_val = MAX_V[OUT_WIDTH-1:0];
      end else if (rectified < MIN_V) begin
         sat_val = MIN_V[OUT_WIDTH-1:0];
      end else begin
         sat_val = rectified[OUT_WIDTH-1:0];
         sat_hit = 1'b0;
      end
   end

   assign accept    = (state_q == COLLECT) && i_en;
   assign fetch     = (state_q == DRAIN) && (rd_ptr_q < RW'(N)) && (!valid_q || i_ready);
   // rd_ptr_q == N means the word on o_data is the final entry of the frame.
   assign last_xfer = (state_q == DRAIN) && valid_q && i_ready && (rd_ptr_q == RW'(N));

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      drop_d   = drop_q | (i_en && (state_q != COLLECT));
      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (wr_ptr_q == AW'(N - 1)) begin
                  wr_ptr_d = '0;
                  state_d  = FLUSH;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         FLUSH: state_d = DRAIN;
         DRAIN: begin
            if (fetch) begin
               rd_ptr_d = rd_ptr_q + RW'(1);
               valid_d  = 1'b1;
            end else if (valid_q && i_ready) begin
               valid_d  = 1'b0;
            end
            if (last_xfer) begin
               state_d  = COLLECT;
               rd_ptr_d = '0;
               valid_d  = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= COLLECT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         drop_q      <= 1'b0;
         ovf_q       <= 1'b0;
         stage_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_q | (accept & sat_hit);
         stage_vld_q <= accept;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         stage_data_q <= sat_val;
         stage_addr_q <= wr_ptr_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (stage_vld_q) begin
         mem[stage_addr_q] <= stage_data_q;
      end
   end

   // Registered read; the fetch enable freezes it while the consumer stalls.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data_q <= '0;
      end else if (fetch) begin
         rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   assign o_data     = rd_data_q;
   assign o_valid    = valid_q;
   assign o_done     = done_q;
   assign o_overflow = ovf_q;
   assign o_drop     = drop_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector with N=9: drives frames, drains them with
// chosen ready patterns and compares against hand-computed words and cycle offsets.
module tb_conv_out_collector;
   localparam int N = 9;

   logic              clk = 1'b0;
   logic              rst, en, relu, ready;
   logic signed [47:0] p;
   logic [5:0]        sh;
   logic signed [15:0] data;
   logic              valid, done, ovf, drop;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic signed [47:0] fv_p [N];
   logic [5:0]         fv_sh [N];
   logic               fv_relu [N];
   int                 exp_v [N];
   int                 got_d [16];
   int t_last, n_got, first_valid, done_cyc, done_count, stall_viol, stall_seen, early_valid;

   conv_out_collector #(.KERNEL_SIZE(2), .FM_SIZE(4), .OUT_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_P(p), .i_en(en), .i_shift(sh), .i_relu(relu),
      .o_data(data), .o_valid(valid), .i_ready(ready), .o_done(done),
      .o_overflow(ovf), .o_drop(drop)
   );

   task automatic send_frame(input int from);
      for (int i = from; i < N; i++) begin
         @(posedge clk); #1;
         en = 1'b1; p = fv_p[i]; sh = fv_sh[i]; relu = fv_relu[i]; ready = 1'b1;
         t_last = cyc;
      end
   endtask

   // rmode 0: ready always 1; rmode 1: ready pattern 1,0,0,1 repeating.
   task automatic collect(input int rmode, input int drop_at, input int bb_p);
      int c;
      logic pv, pr;
      logic signed [15:0] pd;
      n_got = 0; first_valid = -1; done_cyc = -1; done_count = 0;
      stall_viol = 0; stall_seen = 0; early_valid = 0;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int i = 0; i < 16; i++) got_d[i] = -99999;
      for (int k = 0; k < 80 && done_count == 0; k++) begin
         @(posedge clk); #1;
         c = cyc - t_last;
         en = 1'b0; relu = 1'b0; sh = '0;
         if (drop_at > 0 && c == drop_at) begin en = 1'b1; p = 48'sd77; end
         if (bb_p != 0 && c == 12) begin en = 1'b1; p = 48'(bb_p); end
         ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         @(negedge clk);
         if (valid && c < 3) early_valid++;
         if (valid && first_valid < 0) first_valid = c;
         if (pv && !pr) begin
            stall_seen++;
            if (valid !== 1'b1 || data !== pd) stall_viol++;
         end
         if (valid && ready && n_got < 16) begin got_d[n_got] = int'(data); n_got++; end
         if (done) begin done_count++; done_cyc = c; end
         pv = valid; pr = ready; pd = data;
      end
   endtask

   task automatic check_seq(input string name);
      checks++;
      if (n_got !== N) begin
         errors++; $display("FAIL %s count: got %0d expected %0d", name, n_got, N);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_d[i] !== exp_v[i]) begin
            errors++; $display("FAIL %s word%0d: got %0d expected %0d", name, i, got_d[i], exp_v[i]);
         end
      end
      checks++;
      if (done_count !== 1) begin
         errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; p = 48'sd5; sh = '0; relu = 1'b0; ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", valid); end
      checks++; if (data !== 16'sd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", data); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %0b expected 0", drop); end
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b0;
      $display("reset: done");
   endtask

   task automatic test_nominal();
      for (int i = 0; i < N; i++) begin
         fv_p[i] = 48'(i + 1); fv_sh[i] = '0; fv_relu[i] = 1'b0; exp_v[i] = i + 1;
      end
      send_frame(0);
      collect(0, 0, 0);
      check_seq("nominal");
      checks++; if (first_valid !== 3) begin errors++; $display("FAIL nom_first_valid: got T+%0d expected T+3", first_valid); end
      checks++; if (done_cyc !== 12) begin errors++; $display("FAIL nom_done_cycle: got T+%0d expected T+12", done_cyc); end
      checks++; if (early_valid !== 0) begin errors++; $display("FAIL nom_valid_in_flush: got %0d expected 0", early_valid); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nom_valid_at_done: got %0b expected 0", valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_width: got %0b expected 0", done); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL nom_ovf: got %0b expected 0", ovf); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL nom_drop: got %0b expected 0", drop); end
      $display("nominal: %0d words, first T+%0d, done T+%0d", n_got, first_valid, done_cyc);
   endtask

   task automatic test_sat_relu();
      fv_p[0] = 48'sd100000;  fv_p[1] = -48'sd100000; fv_p[2] = -48'sd5;
      fv_p[3] = 48'sd3;       fv_p[4] = -48'sd7;      fv_p[5] = 48'sd1000;
      fv_p[6] = 48'sd0;       fv_p[7] = 48'sd42;      fv_p[8] = -48'sd1;
      exp_v[0] = 32767; exp_v[1] = -32768; exp_v[2] = 0; exp_v[3] = 3; exp_v[4] = -7;
      exp_v[5] = 1000;  exp_v[6] = 0;      exp_v[7] = 42; exp_v[8] = -1;
      for (int i = 0; i < N; i++) begin fv_sh[i] = '0; fv_relu[i] = (i == 2 || i == 5); end
      send_frame(0);
      collect(0, 0, 0);
      check_seq("satrelu");
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0b expected 1", ovf); end
      $display("sat_relu: %0d words, ovf=%0b", n_got, ovf);
   endtask

   task automatic test_shift();
      fv_p[0] = -48'sd17; fv_p[1] = 48'sd35; fv_p[2] = -48'sd16; fv_p[3] = 48'sd0;
      fv_p[4] = 48'sd16;  fv_p[5] = 48'sd15; fv_p[6] = -48'sd1;  fv_p[7] = 48'sd100;
      fv_p[8] = -48'sd100;
      exp_v[0] = -2; exp_v[1] = 2; exp_v[2] = -1; exp_v[3] = 0; exp_v[4] = 1;
      exp_v[5] = 0;  exp_v[6] = -1; exp_v[7] = 6; exp_v[8] = -7;
      for (int i = 0; i < N; i++) begin fv_sh[i] = 6'd4; fv_relu[i] = 1'b0; end
      send_frame(0);
      collect(0, 0, 0);
      check_seq("shift");
      $display("shift: %0d words", n_got);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) begin
         fv_p[i] = 48'(11 + i); fv_sh[i] = '0; fv_relu[i] = 1'b0; exp_v[i] = 11 + i;
      end
      send_frame(0);
      collect(1, 0, 0);
      check_seq("backpressure");
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
      checks++; if (stall_seen < 4) begin errors++; $display("FAIL bp_stalls: got %0d expected >=4", stall_seen); end
      $display("backpressure: %0d words, %0d stalls", n_got, stall_seen);
   endtask

   task automatic test_drop();
      for (int i = 0; i < N; i++) begin
         fv_p[i] = 48'(21 + i); fv_sh[i] = '0; fv_relu[i] = 1'b0; exp_v[i] = 21 + i;
      end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_before: got %0b expected 0", drop); end
      send_frame(0);
      collect(0, 5, 0);
      check_seq("drop");
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL drop_flag: got %0b expected 1", drop); end
      $display("drop: %0d words, drop=%0b", n_got, drop);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) begin
         fv_p[i] = 48'(61 + i); fv_sh[i] = '0; fv_relu[i] = 1'b0; exp_v[i] = 61 + i;
      end
      send_frame(0);
      collect(0, 0, 51);
      check_seq("b2b_first");
      for (int i = 0; i < N; i++) begin fv_p[i] = 48'(51 + i); exp_v[i] = 51 + i; end
      send_frame(1);
      collect(0, 0, 0);
      check_seq("b2b_second");
      checks++; if (first_valid !== 3) begin errors++; $display("FAIL b2b_first_valid: got T+%0d expected T+3", first_valid); end
      $display("back_to_back: %0d words", n_got);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < N; i++) begin
         fv_p[i] = 48'(31 + i); fv_sh[i] = '0; fv_relu[i] = 1'b0;
      end
      send_frame(0);
      repeat (4) begin @(posedge clk); #1; en = 1'b0; ready = 1'b1; end
      @(negedge clk);
      checks++; if (valid !== 1'b1 || data !== 16'sd32) begin
         errors++; $display("FAIL mid_pre_reset: got valid=%0b data=%0d expected valid=1 data=32", valid, data);
      end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", valid); end
      checks++; if (drop !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL mid_flags: got drop=%0b ovf=%0b expected 0 0", drop, ovf);
      end
      for (int i = 0; i < N; i++) begin fv_p[i] = 48'(41 + i); exp_v[i] = 41 + i; end
      send_frame(0);
      collect(0, 0, 0);
      check_seq("mid_reset");
      checks++; if (done_cyc !== 12) begin errors++; $display("FAIL mid_done_cycle: got T+%0d expected T+12", done_cyc); end
      $display("mid_reset: %0d words, done T+%0d", n_got, done_cyc);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_sat_relu();
      test_shift();
      test_backpressure();
      test_drop();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
